// File: rtl/cpu_controller.sv
// Eight-phase fetch/decode/execute sequencer for a simple accumulator CPU.
// Outputs are combinational decodes of the current state, opcode and zero; the state advances one phase per clock with no wait states.
// There is no backpressure. ena=0 parks the sequencer in S0, HALTED is left only through rst, and rst is synchronous and active-high.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, HALTED
  } state_t;

  state_t r_state;

  logic w_alu_op;
  logic w_skip;

  // Opcodes that fetch an operand from memory and load the accumulator.
  assign w_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  // SKZ is taken when the accumulator is zero. zero is sampled live in each execute cycle.
  assign w_skip   = (opcode == OP_SKZ) && zero;

  // Phase sequencer. HALTED is sticky against ena and is left only through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
    end else if (r_state == HALTED) begin
      r_state <= HALTED;
    end else if (!ena) begin
      r_state <= S0;
    end else begin
      case (r_state)
        S0:      r_state <= S1;
        S1:      r_state <= S2;
        S2:      r_state <= S3;
        S3:      r_state <= (opcode == OP_HLT) ? HALTED : S4;
        S4:      r_state <= S5;
        S5:      r_state <= S6;
        S6:      r_state <= S7;
        S7:      r_state <= S0;
        default: r_state <= S0;
      endcase
    end
  end

  // Control decode. HALTED keeps halt visible even while ena is low, because
  // the CPU remains stopped until rst.
  always_comb begin
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    if (!rst) begin
      if (r_state == HALTED) begin
        halt = 1'b1;
      end else if (ena) begin
        case (r_state)
          // Two byte fetches load IR high, then IR low.
          S0, S1: begin
            load_ir = 1'b1;
            rd      = 1'b1;
            inc_pc  = 1'b1;
          end
          S3: begin
            halt = (opcode == OP_HLT);
          end
          S4: begin
            if (opcode == OP_JMP)      load_pc     = 1'b1;
            else if (w_alu_op)         rd          = 1'b1;
            else if (opcode == OP_STO) datactl_ena = 1'b1;
          end
          S5: begin
            if (w_alu_op) begin
              rd       = 1'b1;
              load_acc = 1'b1;
            end else if (opcode == OP_STO) begin
              wr          = 1'b1;
              datactl_ena = 1'b1;
            end else if (opcode == OP_JMP) begin
              load_pc = 1'b1;
            end else if (w_skip) begin
              inc_pc = 1'b1;
            end
          end
          S6: begin
            if (opcode == OP_STO) datactl_ena = 1'b1;
            else if (w_skip)      inc_pc      = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed opcode scenarios and a randomized run checked against a phase-counter model.
// Inputs change 1 ns after posedge. Outputs are sampled 3 ns after posedge.
// Mutual-exclusion checks run on every negedge.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;

  int total;
  int bad;

  // Model state: position within the 8-cycle instruction, plus the halted flag.
  int mdl_phase;
  bit mdl_halted;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDO = 3'd3,
                         XORO = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  localparam logic [7:0] FETCH = 8'b1100_1000;

  wire [7:0] dut_o = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt};

  cpu_controller dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs, built from the per-phase behaviour of the instruction.
  // Bit order is {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}.
  function automatic logic [7:0] model_out(int ph, bit hl, logic r, logic e,
                                           logic [2:0] op, logic z);
    logic [7:0] o;
    bit alu;
    o = 8'h00;
    alu = (op == ADD) || (op == ANDO) || (op == XORO) || (op == LDA);
    if (r) return 8'h00;
    if (hl) return 8'h01;
    if (!e) return 8'h00;
    case (ph)
      0, 1: o = FETCH;
      3: if (op == HLT) o[0] = 1'b1;
      4: begin
        if (op == JMP) o[5] = 1'b1;
        else if (alu) o[3] = 1'b1;
        else if (op == STO) o[1] = 1'b1;
      end
      5: begin
        if (alu) begin o[3] = 1'b1; o[4] = 1'b1; end
        else if (op == STO) begin o[2] = 1'b1; o[1] = 1'b1; end
        else if (op == JMP) o[5] = 1'b1;
        else if (op == SKZ && z) o[6] = 1'b1;
      end
      6: begin
        if (op == STO) o[1] = 1'b1;
        else if (op == SKZ && z) o[6] = 1'b1;
      end
      default: o = 8'h00;
    endcase
    return o;
  endfunction

  // Advance one clock edge. The model updates with the same inputs the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mdl_phase = 0;
      mdl_halted = 1'b0;
    end else if (mdl_halted) begin
      mdl_halted = 1'b1;
    end else if (!ena) begin
      mdl_phase = 0;
    end else if (mdl_phase == 3 && opcode == HLT) begin
      mdl_halted = 1'b1;
    end else begin
      mdl_phase = (mdl_phase + 1) % 8;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Mutual-exclusion checks run in every cycle of every scenario.
  always @(negedge clk) begin
    total++;
    if (rd === 1'b1 && wr === 1'b1) begin
      bad++;
      $display("FAIL rd_wr_excl t=%0t rd=%b wr=%b required not both 1", $time, rd, wr);
    end
    total++;
    if (load_pc === 1'b1 && inc_pc === 1'b1) begin
      bad++;
      $display("FAIL pc_excl t=%0t load_pc=%b inc_pc=%b required not both 1", $time, load_pc, inc_pc);
    end
  end

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; opcode = LDA; zero = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      total++;
      if (dut_o !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=%b", i, dut_o, 8'h00);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    total++;
    if (dut_o !== FETCH) begin
      bad++;
      $display("FAIL reset_first_fetch got=%b want=%b", dut_o, FETCH);
    end
    tick();
  endtask

  task automatic test_lda();
    opcode = LDA; ena = 1'b1; zero = 1'b0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      #2;
      total++;
      if (load_ir !== ((c % 8) < 2)) begin
        bad++;
        $display("FAIL lda_load_ir cyc=%0d got=%b want=%b", c, load_ir, ((c % 8) < 2));
      end
      total++;
      if (rd !== ((c % 8) inside {0, 1, 4, 5})) begin
        bad++;
        $display("FAIL lda_rd cyc=%0d got=%b want=%b", c, rd, ((c % 8) inside {0, 1, 4, 5}));
      end
      total++;
      if (load_acc !== ((c % 8) == 5)) begin
        bad++;
        $display("FAIL lda_load_acc cyc=%0d got=%b want=%b", c, load_acc, ((c % 8) == 5));
      end
      tick();
    end
  endtask

  task automatic test_sto();
    opcode = STO; ena = 1'b1; zero = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      #2;
      total++;
      if (datactl_ena !== (c >= 4 && c <= 6)) begin
        bad++;
        $display("FAIL sto_datactl cyc=%0d got=%b want=%b", c, datactl_ena, (c >= 4 && c <= 6));
      end
      total++;
      if (wr !== (c == 5)) begin
        bad++;
        $display("FAIL sto_wr cyc=%0d got=%b want=%b", c, wr, (c == 5));
      end
      if (c >= 4) begin
        total++;
        if (rd !== 1'b0) begin
          bad++;
          $display("FAIL sto_rd cyc=%0d got=%b want=0", c, rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_skz();
    opcode = SKZ; ena = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      do_reset();
      for (int c = 0; c < 8; c++) begin
        #2;
        total++;
        if (inc_pc !== ((c < 2) || (z == 1 && (c == 5 || c == 6)))) begin
          bad++;
          $display("FAIL skz_inc_pc zero=%0d cyc=%0d got=%b want=%b", z, c, inc_pc,
                   ((c < 2) || (z == 1 && (c == 5 || c == 6))));
        end
        tick();
      end
    end
    // zero changes between S5 and S6; each cycle follows its own sample.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      zero = (c == 5);
      #2;
      total++;
      if (inc_pc !== ((c < 2) || c == 5)) begin
        bad++;
        $display("FAIL skz_zero_live cyc=%0d got=%b want=%b", c, inc_pc, ((c < 2) || c == 5));
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    opcode = HLT; ena = 1'b1; zero = 1'b0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c >= 4) ena = $urandom_range(0, 1);
      #2;
      total++;
      if (dut_o[7:1] !== 7'h00 && c >= 2) begin
        bad++;
        $display("FAIL hlt_others cyc=%0d got=%b want=0000000", c, dut_o[7:1]);
      end
      if (ena) begin
        total++;
        if (halt !== (c >= 3)) begin
          bad++;
          $display("FAIL hlt_halt cyc=%0d got=%b want=%b", c, halt, (c >= 3));
        end
      end
      tick();
    end
    ena = 1'b1;
    rst = 1'b1;
    #2;
    total++;
    if (dut_o !== 8'h00) begin
      bad++;
      $display("FAIL hlt_rst_outputs got=%b want=%b", dut_o, 8'h00);
    end
    tick();
    rst = 1'b0;
    opcode = LDA;
    #2;
    total++;
    if (dut_o !== FETCH) begin
      bad++;
      $display("FAIL hlt_after_rst got=%b want=%b", dut_o, FETCH);
    end
    tick();
  endtask

  task automatic test_jmp();
    opcode = JMP; ena = 1'b1; zero = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    #2;
    total++;
    if (load_pc !== 1'b1) begin
      bad++;
      $display("FAIL jmp_c4_load_pc got=%b want=1", load_pc);
    end
    ena = 1'b0;
    #1;
    total++;
    if (dut_o !== 8'h00) begin
      bad++;
      $display("FAIL jmp_ena_drop got=%b want=%b", dut_o, 8'h00);
    end
    tick();
    ena = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #2;
      total++;
      if (load_pc !== (c == 4 || c == 5) || load_ir !== (c < 2)) begin
        bad++;
        $display("FAIL jmp_restart cyc=%0d got load_pc=%b load_ir=%b want load_pc=%b load_ir=%b",
                 c, load_pc, load_ir, (c == 4 || c == 5), (c < 2));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    ena = 1'b1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      ena    = ($urandom_range(0, 9) != 0);
      opcode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : opcode;
      if (opcode == HLT && $urandom_range(0, 3) != 0) opcode = 3'($urandom_range(1, 7));
      zero   = 1'($urandom_range(0, 1));
      #2;
      exp = model_out(mdl_phase, mdl_halted, rst, ena, opcode, zero);
      total++;
      if (mdl_halted && !ena && !rst) begin
        if (dut_o[7:1] !== exp[7:1]) begin
          bad++;
          $display("FAIL random_halted_parked i=%0d got=%b want=%b", i, dut_o[7:1], exp[7:1]);
        end
      end else if (dut_o !== exp) begin
        bad++;
        $display("FAIL random i=%0d op=%0d z=%b ena=%b rst=%b got=%b want=%b",
                 i, opcode, zero, ena, rst, dut_o, exp);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    mdl_phase = 0;
    mdl_halted = 1'b0;
    rst = 1'b1; ena = 1'b0; opcode = LDA; zero = 1'b0;
    #1;
    test_reset();
    test_lda();
    test_sto();
    test_skz();
    test_hlt();
    test_jmp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL provide: clk  input  1  system clock; all state updates on posedge clk.
REQ-002 The block SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 The block SHALL provide: ena  input  1  run enable; 0 = controller parked in S0.
REQ-004 The block SHALL provide: opcode  input  3  instruction opcode, IR bits [15:13].
REQ-005 The block SHALL provide: zero  input  1  accumulator-equals-zero flag.
REQ-006 The block SHALL provide: load_ir  output  1  instruction register byte-load enable.
REQ-007 The block SHALL provide: inc_pc  output  1  program counter increment.
REQ-008 The block SHALL provide: load_pc  output  1  program counter load from IR address.
REQ-009 The block SHALL provide: load_acc  output  1  accumulator load from ALU result.
REQ-010 The block SHALL provide: rd  output  1  memory read strobe.
REQ-011 The block SHALL provide: wr  output  1  memory write strobe.
REQ-012 The block SHALL provide: datactl_ena  output  1  accumulator-to-bus driver enable.
REQ-013 The block SHALL provide: halt  output  1  CPU halted indication.

Function
REQ-014 Opcode encoding SHALL be HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-015 The FSM SHALL have nine states: S0..S7 in fixed sequence, plus HALTED.
REQ-016 All outputs SHALL be combinational decodes of current state, opcode and zero; all SHALL be 0 when rst=1 or ena=0.
REQ-017 With ena=1, the state SHALL advance S0->S1->...->S7->S0 once per clock, with no wait states.
REQ-018 With ena=0, the state SHALL be forced to S0 on the next clock edge.
REQ-019 In S0 and S1, the block SHALL assert load_ir=1, rd=1 and inc_pc=1, so that two consecutive bytes load IR high then low.
REQ-020 In S2, all outputs SHALL be 0 (decode settle).
REQ-021 In S3 with opcode=HLT, halt SHALL be 1 and the next state SHALL be HALTED; for all other opcodes, outputs SHALL be 0.
REQ-022 In S4: JMP -> load_pc=1; ADD/AND/XOR/LDA -> rd=1; STO -> datactl_ena=1; otherwise all outputs 0.
REQ-023 In S5: ADD/AND/XOR/LDA -> rd=1 and load_acc=1; STO -> wr=1 and datactl_ena=1; JMP -> load_pc=1; SKZ with zero=1 -> inc_pc=1.
REQ-024 In S6: STO -> datactl_ena=1; SKZ with zero=1 -> inc_pc=1; otherwise all outputs 0.
REQ-025 In S7, all outputs SHALL be 0, and the next state SHALL be S0.
REQ-026 SKZ with zero=1 SHALL produce exactly two inc_pc pulses (S5, S6), skipping one 2-byte instruction; SKZ with zero=0 SHALL produce none.
REQ-027 zero SHALL be sampled combinationally in each of S5 and S6; a change between S5 and S6 SHALL affect only that cycle.
REQ-028 HALTED: halt SHALL be 1 and all other outputs 0; the state SHALL be exited only by rst, and ena=0 SHALL NOT clear it.
REQ-029 wr and rd SHALL never both be 1 in any cycle; load_pc and inc_pc SHALL never both be 1.
REQ-030 Instruction period SHALL be exactly 8 clocks for every opcode except HLT.

Reset
REQ-031 On a clock edge with rst=1, the state SHALL become S0 regardless of current state, including HALTED or mid-instruction.
REQ-032 While rst=1, all outputs SHALL be 0.
REQ-033 In the first cycle after rst deasserts with ena=1, the state SHALL be S0, with load_ir=rd=inc_pc=1.
REQ-034 No output SHALL be X after the first reset edge.

Verification
REQ-035 Reset, ena=1, opcode=LDA: load_ir pulses in cycles 0-1; rd in cycles 0, 1, 4, 5; load_acc only in cycle 5; repeats every 8 cycles.
REQ-036 opcode=STO: datactl_ena=1 in cycles 4-6; wr=1 only in cycle 5; rd never asserted in cycles 4-7.
REQ-037 opcode=SKZ, zero=1: inc_pc=1 in cycles 0, 1, 5, 6. Repeated with zero=0: inc_pc=1 in cycles 0 and 1 only.
REQ-038 opcode=HLT: halt=1 from cycle 3 onward and held for 20 cycles with ena toggling; rst=1 for one edge -> halt=0 and state S0.
REQ-039 opcode=JMP: load_pc=1 in cycles 4-5. Dropping ena in cycle 4 -> outputs 0 immediately and state S0 on the next edge; raising ena restarts at the S0 fetch.
REQ-040 Across all scenarios, assertions SHALL check that rd and wr are never both high, and that load_pc and inc_pc are never both high.
